// File: rtl/fp_round_unit_pkg.sv
// Shared types and constants for the FP rounding unit: rounding modes,
// the fflags bundle and the special-value encodings.
package fp_round_unit_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rnd_mode_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam logic [31:0] CANO_NAN       = 32'h7FC0_0000;
    localparam logic [31:0] P_INFTY        = 32'h7F80_0000;
    localparam logic [31:0] N_INFTY        = 32'hFF80_0000;
    localparam logic [31:0] MAX_FINITE_MAG = 32'h7F7F_FFFF;

    // On overflow, modes that round away from zero saturate to infinity.
    function automatic logic rounds_away(input rnd_mode_t rm, input logic sign);
        logic away;
        away = 1'b0;
        case (rm)
            RNE, RMM: away = 1'b1;
            RUP:      away = ~sign;
            RDN:      away = sign;
            default:  away = 1'b0;
        endcase
        return away;
    endfunction

endpackage

// File: rtl/fp_round_decide.sv
// Combinational increment/inexact decision from sign, lsb, guard/round/sticky
// and the RISC-V rounding mode. Shared with the conversion path.
module fp_round_decide
    import fp_round_unit_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic       guard,
    input  logic       round,
    input  logic       sticky,
    input  logic [2:0] frm,
    output logic       inc,
    output logic       inexact,
    output logic       illegal_rm
);

    always_comb begin
        inexact    = guard | round | sticky;
        inc        = 1'b0;
        illegal_rm = 1'b0;
        case (rnd_mode_t'(frm))
            RNE:     inc = guard & (round | sticky | lsb);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & inexact;
            RUP:     inc = ~sign & inexact;
            RMM:     inc = guard;
            default: illegal_rm = 1'b1;
        endcase
    end

endmodule

// File: rtl/fp_round_unit.sv
// Two-stage RISC-V rounding pipeline: stage 1 classifies and decides the
// increment, stage 2 applies it with overflow/special handling and flags.
module fp_round_unit
    import fp_round_unit_pkg::*;
#(
    parameter bit ACC_FLAGS_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    input  logic [31:0] operand_i,
    input  logic [2:0]  round_bits_i,
    input  logic [2:0]  frm_i,
    input  logic        invalid_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    input  logic        clear_flags_i,
    output logic [31:0] result_o,
    output logic        valid_o,
    output logic [4:0]  fflags_o,
    output logic [4:0]  fflags_acc_o
);

    logic        dec_inc;
    logic        dec_inexact;
    logic        dec_illegal;

    logic        s1_valid;
    logic [31:0] s1_operand;
    logic        s1_inc;
    logic        s1_inexact;
    logic        s1_illegal;
    logic        s1_is_nan;
    logic        s1_is_inf;
    rnd_mode_t   s1_rm;
    logic        s1_invalid;
    logic        s1_overflow;
    logic        s1_underflow;

    logic [30:0] sum;
    logic [31:0] s2_result;
    fflags_t     s2_flags;

    fp_round_decide u_decide (
        .sign       (operand_i[31]),
        .lsb        (operand_i[0]),
        .guard      (round_bits_i[2]),
        .round      (round_bits_i[1]),
        .sticky     (round_bits_i[0]),
        .frm        (frm_i),
        .inc        (dec_inc),
        .inexact    (dec_inexact),
        .illegal_rm (dec_illegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid     <= 1'b0;
            s1_operand   <= '0;
            s1_inc       <= 1'b0;
            s1_inexact   <= 1'b0;
            s1_illegal   <= 1'b0;
            s1_is_nan    <= 1'b0;
            s1_is_inf    <= 1'b0;
            s1_rm        <= RNE;
            s1_invalid   <= 1'b0;
            s1_overflow  <= 1'b0;
            s1_underflow <= 1'b0;
        end else if (clk_en_i) begin
            s1_valid     <= valid_i;
            s1_operand   <= operand_i;
            s1_inc       <= dec_inc;
            s1_inexact   <= dec_inexact;
            s1_illegal   <= dec_illegal;
            s1_is_nan    <= (operand_i[30:23] == 8'hFF) && (operand_i[22:0] != '0);
            s1_is_inf    <= (operand_i[30:23] == 8'hFF) && (operand_i[22:0] == '0);
            s1_rm        <= rnd_mode_t'(frm_i);
            s1_invalid   <= invalid_i;
            s1_overflow  <= overflow_i;
            s1_underflow <= underflow_i;
        end
    end

    // A mantissa carry out of the 31-bit add bumps the exponent for free.
    always_comb begin
        sum       = s1_operand[30:0] + {30'd0, s1_inc};
        s2_result = '0;
        s2_flags  = '0;
        if (s1_illegal) begin
            s2_result   = CANO_NAN;
            s2_flags.nv = 1'b1;
        end else begin
            s2_flags.nv = s1_invalid;
            s2_flags.uf = s1_underflow;
            if (s1_is_nan) begin
                s2_result = CANO_NAN;
            end else if (s1_is_inf) begin
                s2_result = s1_operand;
            end else if ((sum[30:23] == 8'hFF) || s1_overflow) begin
                s2_result   = rounds_away(s1_rm, s1_operand[31])
                              ? (s1_operand[31] ? N_INFTY : P_INFTY)
                              : {s1_operand[31], MAX_FINITE_MAG[30:0]};
                s2_flags.of = 1'b1;
                s2_flags.nx = 1'b1;
            end else begin
                s2_result   = {s1_operand[31], sum};
                s2_flags.uf = s1_underflow | ((sum[30:23] == 8'h00) & s1_inexact);
                s2_flags.nx = s1_inexact;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            fflags_o <= '0;
        end else if (clk_en_i) begin
            valid_o  <= s1_valid;
            result_o <= s1_valid ? s2_result : '0;
            fflags_o <= s1_valid ? s2_flags : '0;
        end
    end

    generate
        if (ACC_FLAGS_EN) begin : g_acc
            logic [4:0] acc_q;
            // Clear is honoured even while the pipeline is frozen.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    acc_q <= '0;
                end else if (clk_en_i) begin
                    acc_q <= (clear_flags_i ? 5'd0 : acc_q) | (s1_valid ? s2_flags : 5'd0);
                end else if (clear_flags_i) begin
                    acc_q <= '0;
                end
            end
            assign fflags_acc_o = acc_q;
        end else begin : g_no_acc
            assign fflags_acc_o = '0;
        end
    endgenerate

endmodule

// File: tb/tb_fp_round_unit.sv
// Scoreboard bench for fp_round_unit: expected results are queued at issue
// and compared when the pipeline delivers each result.
module tb_fp_round_unit;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clk_en_i;
    logic        valid_i;
    logic [31:0] operand_i;
    logic [2:0]  round_bits_i;
    logic [2:0]  frm_i;
    logic        invalid_i;
    logic        overflow_i;
    logic        underflow_i;
    logic        clear_flags_i;
    logic [31:0] result_o;
    logic        valid_o;
    logic [4:0]  fflags_o;
    logic [4:0]  fflags_acc_o;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic adv      = 1'b0;

    fp_round_unit #(.ACC_FLAGS_EN(1'b1)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clk_en_i      (clk_en_i),
        .valid_i       (valid_i),
        .operand_i     (operand_i),
        .round_bits_i  (round_bits_i),
        .frm_i         (frm_i),
        .invalid_i     (invalid_i),
        .overflow_i    (overflow_i),
        .underflow_i   (underflow_i),
        .clear_flags_i (clear_flags_i),
        .result_o      (result_o),
        .valid_o       (valid_o),
        .fflags_o      (fflags_o),
        .fflags_acc_o  (fflags_acc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Remember whether the last edge actually advanced the pipeline.
    always @(posedge clk_i) adv <= clk_en_i && !rst_i;

    always @(negedge clk_i) begin
        if (adv && !rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check_eq("result", result_o, e.res);
                check_eq("fflags", 32'(fflags_o), 32'(e.fl));
            end
        end
    end

    task automatic drive(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] frm,
                         input logic inv, input logic ovf, input logic unf);
        valid_i      = 1'b1;
        operand_i    = op;
        round_bits_i = grs;
        frm_i        = frm;
        invalid_i    = inv;
        overflow_i   = ovf;
        underflow_i  = unf;
    endtask

    task automatic send(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] frm,
                        input logic inv, input logic ovf, input logic unf,
                        input logic [31:0] er, input logic [4:0] ef);
        exp_t e;
        drive(op, grs, frm, inv, ovf, unf);
        e.res = er;
        e.fl  = ef;
        exp_q.push_back(e);
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        valid_i = 1'b0;
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1; clk_en_i = 1'b1; valid_i = 1'b0; operand_i = '0; round_bits_i = '0;
        frm_i = '0; invalid_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0; clear_flags_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        check_eq("rst_fflags", 32'(fflags_o), 32'd0);
        check_eq("rst_acc", 32'(fflags_acc_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Rounding modes, carries, overflow, specials, illegal mode.
        send(32'h3F800000, 3'b100, 3'b000, 0, 0, 0, 32'h3F800000, 5'b00001);
        send(32'h3F800001, 3'b100, 3'b000, 0, 0, 0, 32'h3F800002, 5'b00001);
        send(32'h3FFFFFFF, 3'b110, 3'b000, 0, 0, 0, 32'h40000000, 5'b00001);
        send(32'h3FFFFFFF, 3'b110, 3'b001, 0, 0, 0, 32'h3FFFFFFF, 5'b00001);
        send(32'h7F7FFFFF, 3'b100, 3'b000, 0, 0, 0, 32'h7F800000, 5'b00101);
        send(32'hFF7FFFFF, 3'b100, 3'b010, 0, 0, 0, 32'hFF800000, 5'b00101);
        send(32'hFF7FFFFF, 3'b100, 3'b011, 0, 0, 0, 32'hFF7FFFFF, 5'b00001);
        send(32'h7FC00123, 3'b111, 3'b000, 0, 0, 0, 32'h7FC00000, 5'b00000);
        send(32'hFF800000, 3'b111, 3'b000, 0, 0, 0, 32'hFF800000, 5'b00000);
        send(32'h3F800000, 3'b100, 3'b101, 0, 0, 0, 32'h7FC00000, 5'b10000);
        send(32'h3F800000, 3'b000, 3'b000, 1, 0, 0, 32'h3F800000, 5'b10000);
        send(32'h3F800000, 3'b000, 3'b001, 0, 1, 0, 32'h7F7FFFFF, 5'b00101);
        send(32'h007FFFFF, 3'b010, 3'b001, 0, 0, 0, 32'h007FFFFF, 5'b00011);
        send(32'h007FFFFF, 3'b110, 3'b000, 0, 0, 0, 32'h00800000, 5'b00001);
        send(32'h3F800000, 3'b100, 3'b100, 0, 0, 0, 32'h3F800001, 5'b00001);
        send(32'hBF800000, 3'b001, 3'b010, 0, 0, 0, 32'hBF800001, 5'b00001);
        send(32'h40490FDB, 3'b000, 3'b000, 0, 0, 0, 32'h40490FDB, 5'b00000);
        idle(4);

        // Back-to-back ops with a two-cycle freeze mid-stream.
        send(32'h3F800001, 3'b100, 3'b000, 0, 0, 0, 32'h3F800002, 5'b00001);
        send(32'h40000000, 3'b000, 3'b000, 0, 0, 0, 32'h40000000, 5'b00000);
        begin
            exp_t e;
            drive(32'h3FFFFFFF, 3'b110, 3'b000, 0, 0, 0);
            e.res = 32'h40000000; e.fl = 5'b00001;
            exp_q.push_back(e);
        end
        clk_en_i = 1'b0;
        @(negedge clk_i);
        check_eq("stall_valid_1", 32'(valid_o), 32'd1);
        check_eq("stall_result_1", result_o, 32'h3F800002);
        @(negedge clk_i);
        check_eq("stall_valid_2", 32'(valid_o), 32'd1);
        check_eq("stall_result_2", result_o, 32'h3F800002);
        clk_en_i = 1'b1;
        @(negedge clk_i);
        idle(4);

        // Accrued flags: clear while frozen, accumulate, clear against new flags.
        clk_en_i = 1'b0; clear_flags_i = 1'b1;
        @(negedge clk_i);
        clear_flags_i = 1'b0; clk_en_i = 1'b1;
        check_eq("acc_clear_frozen", 32'(fflags_acc_o), 32'd0);
        send(32'h3F800000, 3'b100, 3'b000, 0, 0, 0, 32'h3F800000, 5'b00001);
        send(32'h3F800000, 3'b000, 3'b110, 0, 0, 0, 32'h7FC00000, 5'b10000);
        idle(3);
        check_eq("acc_nx_nv", 32'(fflags_acc_o), 32'h11);
        send(32'h7F7FFFFF, 3'b100, 3'b000, 0, 0, 0, 32'h7F800000, 5'b00101);
        clear_flags_i = 1'b1;
        @(negedge clk_i);
        clear_flags_i = 1'b0;
        check_eq("acc_clear_new", 32'(fflags_acc_o), 32'h05);
        idle(3);

        // Asynchronous reset with two ops in flight.
        send(32'h3F800001, 3'b100, 3'b000, 0, 0, 0, 32'h3F800002, 5'b00001);
        drive(32'h3F800000, 3'b100, 3'b000, 0, 0, 0);
        @(negedge clk_i);
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        exp_q.delete();
        check_eq("arst_valid", 32'(valid_o), 32'd0);
        check_eq("arst_result", result_o, 32'd0);
        check_eq("arst_fflags", 32'(fflags_o), 32'd0);
        check_eq("arst_acc", 32'(fflags_acc_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_eq("post_rst_valid", 32'(valid_o), 32'd0);
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
